// File: rtl/y86_exec_ctrl.sv
// Y86-64 execute-stage controller.
// Holds the E pipeline register, selects ALU operands and function, owns the
// condition-code register, and evaluates jump/cmov conditions.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_RUN    | normal operation, OPq may update CC
// S_FROZEN | a non-AOK status reached writeback; CC held until rst
module y86_exec_ctrl #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] STAT_AOK = 3'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E_stall,
  input  logic             E_bubble,
  input  logic [2:0]       D_stat,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       D_ifun,
  input  logic [WIDTH-1:0] D_valA,
  input  logic [WIDTH-1:0] D_valB,
  input  logic [WIDTH-1:0] D_valC,
  input  logic [3:0]       D_dstE,
  input  logic [3:0]       D_dstM,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic [WIDTH-1:0] alu_valE,
  input  logic [2:0]       alu_cc,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic [3:0]       alufun,
  output logic             set_cc,
  output logic [WIDTH-1:0] e_valE,
  output logic [WIDTH-1:0] e_valA,
  output logic [3:0]       e_dstE,
  output logic [3:0]       e_dstM,
  output logic             e_Cnd,
  output logic [3:0]       e_icode,
  output logic [2:0]       e_stat,
  output logic [2:0]       cc_q,
  output logic             frozen
);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_FROZEN = 1'b1;

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_NONE  = 4'hF;

  localparam logic [WIDTH-1:0] C_POS8 = WIDTH'(8);
  localparam logic [WIDTH-1:0] C_NEG8 = {{(WIDTH-4){1'b1}}, 4'b1000};

  logic [2:0]       r_E_stat;
  logic [3:0]       r_E_icode;
  logic [3:0]       r_E_ifun;
  logic [WIDTH-1:0] r_E_valA;
  logic [WIDTH-1:0] r_E_valB;
  logic [WIDTH-1:0] r_E_valC;
  logic [3:0]       r_E_dstE;
  logic [3:0]       r_E_dstM;
  logic [2:0]       r_cc;
  logic [0:0]       r_state;

  logic w_zf, w_sf, w_of, w_lt, w_cond;

  // E pipeline register: reset, then stall (hold), then bubble (nop), then capture
  always_ff @(posedge clk) begin
    if (rst || (!E_stall && E_bubble)) begin
      r_E_stat  <= STAT_AOK;
      r_E_icode <= I_NOP;
      r_E_ifun  <= 4'h0;
      r_E_valA  <= '0;
      r_E_valB  <= '0;
      r_E_valC  <= '0;
      r_E_dstE  <= R_NONE;
      r_E_dstM  <= R_NONE;
    end else if (!E_stall) begin
      r_E_stat  <= D_stat;
      r_E_icode <= D_icode;
      r_E_ifun  <= D_ifun;
      r_E_valA  <= D_valA;
      r_E_valB  <= D_valB;
      r_E_valC  <= D_valC;
      r_E_dstE  <= D_dstE;
      r_E_dstM  <= D_dstM;
    end
  end

  // CC register and freeze FSM; a stalled OPq writes CC only when it leaves E
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cc    <= 3'b100;
      r_state <= S_RUN;
    end else begin
      if (set_cc && !E_stall) r_cc <= alu_cc;
      if (W_stat != STAT_AOK) r_state <= S_FROZEN;
    end
  end

  // Operand/function select and CC write enable
  always_comb begin
    aluA = '0;
    aluB = '0;
    case (r_E_icode)
      I_RRMOV, I_OPQ:          aluA = r_E_valA;
      I_IRMOV, I_RMMOV, I_MRMOV: aluA = r_E_valC;
      I_CALL, I_PUSH:          aluA = C_NEG8;
      I_RET, I_POP:            aluA = C_POS8;
      default:                 aluA = '0;
    endcase
    case (r_E_icode)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: aluB = r_E_valB;
      default: aluB = '0;
    endcase
    alufun = (r_E_icode == I_OPQ) ? r_E_ifun : 4'h0;
    set_cc = (r_E_icode == I_OPQ) && (r_E_stat == STAT_AOK) &&
             (m_stat == STAT_AOK) && (W_stat == STAT_AOK) && (r_state == S_RUN);
  end

  // Jump/cmov condition from the CC value held before this cycle's update
  always_comb begin
    w_zf   = r_cc[2];
    w_sf   = r_cc[1];
    w_of   = r_cc[0];
    w_lt   = w_sf ^ w_of;
    w_cond = 1'b0;
    case (r_E_ifun)
      4'h0:    w_cond = 1'b1;
      4'h1:    w_cond = w_lt | w_zf;
      4'h2:    w_cond = w_lt;
      4'h3:    w_cond = w_zf;
      4'h4:    w_cond = ~w_zf;
      4'h5:    w_cond = ~w_lt;
      4'h6:    w_cond = ~w_lt & ~w_zf;
      default: w_cond = 1'b0;
    endcase
  end

  assign e_Cnd   = ((r_E_icode == I_RRMOV) || (r_E_icode == I_JXX)) ? w_cond : 1'b0;
  assign e_dstE  = ((r_E_icode == I_RRMOV) && !e_Cnd) ? R_NONE : r_E_dstE;
  assign e_valE  = alu_valE;
  assign e_valA  = r_E_valA;
  assign e_dstM  = r_E_dstM;
  assign e_icode = r_E_icode;
  assign e_stat  = r_E_stat;
  assign cc_q    = r_cc;
  assign frozen  = (r_state == S_FROZEN);

endmodule

// File: tb/tb_y86_exec_ctrl.sv
// Scoreboard bench for y86_exec_ctrl: a reference model predicts each
// cycle's outputs, a monitor compares them at the falling edge.
module tb_y86_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst, E_stall, E_bubble;
  logic [2:0]  D_stat, m_stat, W_stat;
  logic [3:0]  D_icode, D_ifun, D_dstE, D_dstM;
  logic [63:0] D_valA, D_valB, D_valC;
  logic [63:0] alu_valE;
  logic [2:0]  alu_cc;
  logic [63:0] aluA, aluB, e_valE, e_valA;
  logic [3:0]  alufun, e_dstE, e_dstM, e_icode;
  logic        set_cc, e_Cnd, frozen;
  logic [2:0]  e_stat, cc_q;

  always #5 clk = ~clk;

  y86_exec_ctrl dut (
    .clk(clk), .rst(rst), .E_stall(E_stall), .E_bubble(E_bubble),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_valA(D_valA), .D_valB(D_valB), .D_valC(D_valC),
    .D_dstE(D_dstE), .D_dstM(D_dstM), .m_stat(m_stat), .W_stat(W_stat),
    .alu_valE(alu_valE), .alu_cc(alu_cc),
    .aluA(aluA), .aluB(aluB), .alufun(alufun), .set_cc(set_cc),
    .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .e_Cnd(e_Cnd), .e_icode(e_icode), .e_stat(e_stat), .cc_q(cc_q),
    .frozen(frozen)
  );

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun;
    logic [63:0] valA, valB, valC;
    logic [3:0]  dstE, dstM;
  } einstr_t;

  typedef struct {
    logic    rst, stall, bubble;
    logic [2:0] m_stat, W_stat;
    einstr_t d;
  } stim_t;

  typedef struct {
    logic [63:0] aluA, aluB, valE, valA;
    logic [3:0]  alufun, dstE, dstM, icode;
    logic        set_cc, cnd, frozen;
    logic [2:0]  stat, cc;
  } exp_t;

  // Bench-side ALU: result plus {ZF,SF,OF}
  function automatic logic [66:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                        input logic [3:0] f);
    logic [63:0] r;
    logic        of;
    r = 64'd0; of = 1'b0;
    case (f)
      4'd0: begin r = a + b; of = (a[63] == b[63]) && (r[63] != a[63]); end
      4'd1: begin r = b - a; of = (a[63] != b[63]) && (r[63] != b[63]); end
      4'd2: r = a & b;
      4'd3: r = a ^ b;
      default: r = 64'd0;
    endcase
    return {r, (r == 64'd0), r[63], of};
  endfunction

  assign {alu_valE, alu_cc} = alu_f(aluA, aluB, alufun);

  function automatic logic cond_f(input logic [2:0] cc, input logic [3:0] fn);
    logic zf, lt;
    zf = cc[2];
    lt = cc[1] != cc[0];
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic einstr_t nop_i();
    einstr_t n;
    n.stat = 3'd1; n.icode = 4'h1; n.ifun = 4'h0;
    n.valA = 64'd0; n.valB = 64'd0; n.valC = 64'd0;
    n.dstE = 4'hF; n.dstM = 4'hF;
    return n;
  endfunction

  function automatic stim_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] c);
    stim_t s;
    s.rst = 1'b0; s.stall = 1'b0; s.bubble = 1'b0;
    s.m_stat = 3'd1; s.W_stat = 3'd1;
    s.d.stat = 3'd1; s.d.icode = icode; s.d.ifun = ifun;
    s.d.valA = a; s.d.valB = b; s.d.valC = c;
    s.d.dstE = 4'h3; s.d.dstM = 4'h5;
    return s;
  endfunction

  // Reference model state
  einstr_t m_e;
  logic [2:0] m_cc;
  logic       m_frozen;
  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic cycle(input stim_t s);
    exp_t x;
    logic [66:0] r;
    #2;
    rst = s.rst; E_stall = s.stall; E_bubble = s.bubble;
    m_stat = s.m_stat; W_stat = s.W_stat;
    D_stat = s.d.stat; D_icode = s.d.icode; D_ifun = s.d.ifun;
    D_valA = s.d.valA; D_valB = s.d.valB; D_valC = s.d.valC;
    D_dstE = s.d.dstE; D_dstM = s.d.dstM;

    if (m_e.icode == 4'h2 || m_e.icode == 4'h6)      x.aluA = m_e.valA;
    else if (m_e.icode inside {4'h3, 4'h4, 4'h5})    x.aluA = m_e.valC;
    else if (m_e.icode == 4'h8 || m_e.icode == 4'hA) x.aluA = 64'd0 - 64'd8;
    else if (m_e.icode == 4'h9 || m_e.icode == 4'hB) x.aluA = 64'd8;
    else                                             x.aluA = 64'd0;
    x.aluB   = (m_e.icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? m_e.valB : 64'd0;
    x.alufun = (m_e.icode == 4'h6) ? m_e.ifun : 4'h0;
    r        = alu_f(x.aluA, x.aluB, x.alufun);
    x.valE   = r[66:3];
    x.set_cc = (m_e.icode == 4'h6) && (m_e.stat == 3'd1) && (s.m_stat == 3'd1) &&
               (s.W_stat == 3'd1) && !m_frozen;
    x.cnd    = (m_e.icode == 4'h2 || m_e.icode == 4'h7) ? cond_f(m_cc, m_e.ifun) : 1'b0;
    x.dstE   = (m_e.icode == 4'h2 && !x.cnd) ? 4'hF : m_e.dstE;
    x.valA = m_e.valA; x.dstM = m_e.dstM; x.icode = m_e.icode; x.stat = m_e.stat;
    x.cc = m_cc; x.frozen = m_frozen;
    sb_q.push_back(x);

    if (s.rst) begin
      m_e = nop_i(); m_cc = 3'b100; m_frozen = 1'b0;
    end else begin
      if (x.set_cc && !s.stall) m_cc = r[2:0];
      if (s.W_stat != 3'd1) m_frozen = 1'b1;
      if (!s.stall) m_e = s.bubble ? nop_i() : s.d;
    end
    @(posedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Monitor: every cycle the DUT presents the E-stage result of one instruction
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk("aluA",    aluA,    x.aluA);
        chk("aluB",    aluB,    x.aluB);
        chk("alufun",  {60'd0, alufun},  {60'd0, x.alufun});
        chk("set_cc",  {63'd0, set_cc},  {63'd0, x.set_cc});
        chk("e_valE",  e_valE,  x.valE);
        chk("e_valA",  e_valA,  x.valA);
        chk("e_dstE",  {60'd0, e_dstE},  {60'd0, x.dstE});
        chk("e_dstM",  {60'd0, e_dstM},  {60'd0, x.dstM});
        chk("e_Cnd",   {63'd0, e_Cnd},   {63'd0, x.cnd});
        chk("e_icode", {60'd0, e_icode}, {60'd0, x.icode});
        chk("e_stat",  {61'd0, e_stat},  {61'd0, x.stat});
        chk("cc_q",    {61'd0, cc_q},    {61'd0, x.cc});
        chk("frozen",  {63'd0, frozen},  {63'd0, x.frozen});
      end
    end
  end

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return {60'd0, 4'($urandom_range(0, 15))};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.rst    = ($urandom_range(0, 59) == 0);
    s.stall  = ($urandom_range(0, 5) == 0);
    s.bubble = ($urandom_range(0, 5) == 0);
    s.m_stat = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
    s.W_stat = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
    s.d.icode = 4'($urandom_range(0, 11));
    s.d.ifun  = (s.d.icode inside {4'h2, 4'h6, 4'h7}) ? 4'($urandom_range(0, 7)) : 4'h0;
    if (s.d.icode == 4'h6 && s.d.ifun > 4'd3) s.d.stat = 3'd4;
    else s.d.stat = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 3)) : 3'd1;
    s.d.valA = rnd_val(); s.d.valB = rnd_val(); s.d.valC = rnd_val();
    s.d.dstE = 4'($urandom_range(0, 15)); s.d.dstM = 4'($urandom_range(0, 15));
    return s;
  endfunction

  initial begin
    stim_t s;
    rst = 1'b1; E_stall = 1'b0; E_bubble = 1'b0;
    m_stat = 3'd1; W_stat = 3'd1;
    D_stat = 3'd1; D_icode = 4'h1; D_ifun = 4'h0;
    D_valA = '0; D_valB = '0; D_valC = '0; D_dstE = 4'hF; D_dstM = 4'hF;
    repeat (2) @(posedge clk);
    m_e = nop_i(); m_cc = 3'b100; m_frozen = 1'b0;

    // Directed: reset state observed, OPq add/sub, cmov/jump conditions
    cycle(mk(4'h6, 4'h0, 64'd5, 64'd0 - 64'd5, 64'd0));
    cycle(mk(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0));
    cycle(mk(4'h2, 4'h2, 64'd9, 64'd0, 64'd0));
    cycle(mk(4'h7, 4'h1, 64'd0, 64'd0, 64'h40));
    cycle(mk(4'h2, 4'h3, 64'd9, 64'd0, 64'd0));
    cycle(mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0));
    // Exception gating and freeze
    cycle(mk(4'h6, 4'h0, 64'd3, 64'd0 - 64'd3, 64'd0));
    s = mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0); s.m_stat = 3'd3; cycle(s);
    s = mk(4'h6, 4'h3, 64'd7, 64'd7, 64'd0); s.W_stat = 3'd2; cycle(s);
    cycle(mk(4'h6, 4'h0, 64'd1, 64'd1, 64'd0));
    cycle(mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0));
    s = mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0); s.rst = 1'b1; cycle(s);
    // Stall/bubble around a pushq
    cycle(mk(4'hA, 4'h0, 64'h55, 64'h100, 64'd0));
    repeat (3) begin s = mk(4'h9, 4'h0, 64'd0, 64'h200, 64'd0); s.stall = 1'b1; cycle(s); end
    s = mk(4'h9, 4'h0, 64'd0, 64'h200, 64'd0); s.stall = 1'b1; s.bubble = 1'b1; cycle(s);
    s = mk(4'h9, 4'h0, 64'd0, 64'h200, 64'd0); s.bubble = 1'b1; cycle(s);
    // Stalled OPq updates CC once, on leaving E
    cycle(mk(4'h6, 4'h1, 64'd5, 64'd5, 64'd0));
    s = mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0); s.stall = 1'b1; cycle(s);
    // Address/immediate paths
    cycle(mk(4'h5, 4'h0, 64'd0, 64'h1000, 64'h20));
    cycle(mk(4'h3, 4'h0, 64'd0, 64'h1234, 64'd7));
    cycle(mk(4'h9, 4'h0, 64'd0, 64'h200, 64'd0));
    cycle(mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0));

    // Randomised traffic
    repeat (3000) cycle(rnd_stim());

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
